counter_checker: RTL

COUNTER_CHECKER -- requirements
Module: counter_checker

---
 rtl/counter_checker.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/counter_checker.sv
// Self-checking monitor for an up/down counter: a reference counter model,
// latency-matched compare, pass/fail statistics and first-mismatch capture.
module counter_checker #(
    parameter int N            = 8,
    parameter int LAT          = 0,
    parameter int CW           = 16,
    parameter int STOP_ON_FAIL = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          up_dn,
    input  logic          load,
    input  logic [N-1:0]  load_val,
    input  logic          sat_mode,
    input  logic [N-1:0]  dut_count,
    input  logic          chk_en,
    input  logic          clr,
    output logic [CW-1:0] pass_cnt,
    output logic [CW-1:0] fail_cnt,
    output logic          mismatch,
    output logic          err_sticky,
    output logic          first_valid,
    output logic [N-1:0]  first_exp,
    output logic [N-1:0]  first_got,
    output logic [1:0]    state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WARM  = 2'd1,
        ST_CHECK = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam logic [N-1:0]  EXP_ONE = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0]  EXP_MAX = {N{1'b1}};
    localparam logic [N-1:0]  EXP_MIN = {N{1'b0}};
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [2:0]    LAT_W   = 3'(LAT);

    state_t         state_q, state_d;
    logic [2:0]     warm_q, warm_d;
    logic [N-1:0]   exp_q, exp_d;
    logic [N-1:0]   exp_tap;
    logic           do_cmp;
    logic           cmp_pass;
    logic           cmp_fail;

    // ------------------------------------------------------------------
    // Reference counter model: load has priority over count enable.
    // ------------------------------------------------------------------
    always_comb begin
        exp_d = exp_q;
        if (load) begin
            exp_d = load_val;
        end else if (en) begin
            if (!up_dn) begin
                if (!(sat_mode && exp_q == EXP_MAX)) exp_d = exp_q + EXP_ONE;
            end else begin
                if (!(sat_mode && exp_q == EXP_MIN)) exp_d = exp_q - EXP_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) exp_q <= '0;
        else        exp_q <= exp_d;
    end

    // ------------------------------------------------------------------
    // Delay line aligning the model with the DUT's output latency.
    // ------------------------------------------------------------------
    generate
        if (LAT == 0) begin : g_no_dly
            assign exp_tap = exp_q;
        end else begin : g_dly
            logic [N-1:0] dly_q [LAT];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < LAT; i++) dly_q[i] <= '0;
                end else begin
                    dly_q[0] <= exp_q;
                    for (int i = 1; i < LAT; i++) dly_q[i] <= dly_q[i-1];
                end
            end

            assign exp_tap = dly_q[LAT-1];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Compare: only in CHECK with checking enabled.
    // ------------------------------------------------------------------
    assign do_cmp   = (state_q == ST_CHECK) && chk_en;
    assign cmp_pass = do_cmp && (dut_count == exp_tap);
    assign cmp_fail = do_cmp && (dut_count != exp_tap);

    // ------------------------------------------------------------------
    // Checker FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            warm_q  <= '0;
        end else begin
            state_q <= state_d;
            warm_q  <= warm_d;
        end
    end

    always_comb begin
        state_d = state_q;
        warm_d  = warm_q;
        if (clr) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (chk_en) begin
                        state_d = ST_WARM;
                        warm_d  = LAT_W;
                    end
                end
                ST_WARM: begin
                    if (!chk_en) begin
                        state_d = ST_IDLE;
                    end else if (load) begin
                        warm_d = LAT_W;
                    end else if (warm_q == 3'd0) begin
                        state_d = ST_CHECK;
                    end else begin
                        warm_d = warm_q - 3'd1;
                    end
                end
                ST_CHECK: begin
                    // A halting fail outranks a reload: the error must stay visible.
                    if (!chk_en) begin
                        state_d = ST_IDLE;
                    end else if (cmp_fail && STOP_ON_FAIL != 0) begin
                        state_d = ST_HALT;
                    end else if (load) begin
                        state_d = ST_WARM;
                        warm_d  = LAT_W;
                    end
                end
                ST_HALT: begin
                    state_d = ST_HALT;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign state = state_q;

    // ------------------------------------------------------------------
    // Statistics and first-mismatch capture; clr discards a same-edge compare.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt    <= '0;
            fail_cnt    <= '0;
            mismatch    <= 1'b0;
            err_sticky  <= 1'b0;
            first_valid <= 1'b0;
            first_exp   <= '0;
            first_got   <= '0;
        end else if (clr) begin
            pass_cnt    <= '0;
            fail_cnt    <= '0;
            mismatch    <= 1'b0;
            err_sticky  <= 1'b0;
            first_valid <= 1'b0;
            first_exp   <= '0;
            first_got   <= '0;
        end else begin
            mismatch <= cmp_fail;
            if (cmp_pass && pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + CNT_ONE;
            if (cmp_fail) begin
                if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + CNT_ONE;
                err_sticky <= 1'b1;
                if (!first_valid) begin
                    first_valid <= 1'b1;
                    first_exp   <= exp_tap;
                    first_got   <= dut_count;
                end
            end
        end
    end

endmodule
